cbu: RTL and testbench
======================

# cbu

The cbu is a 4-bit computation block with a two-stage registered pipeline. It decodes a 9-bit instruction word, of which only the top 3 bits are used. It performs add, subtract, increment, decrement, magnitude compare, free-running up/down counting, or doubling on 4-bit operands. It sits as a leaf datapath unit under the ALU top level, and its result is registered.

## Interface
- No parameters.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- out  output  4  registered result.
- in  input  9  instruction word; in[8:6] = opcode, in[5:0] reserved/ignored.
- a  input  4  operand A (unsigned).
- b  input  4  operand B (unsigned).
- Positional port order: out, in, a, b, rst, clk.

## Operation
- Stage 1 (input register): each rising edge captures opcode (in[8:6]), a, b.
- Stage 2 (output register): each rising edge computes out from the stage-1 contents.
- All arithmetic is 4-bit unsigned modulo 16; carries and borrows are discarded.
- 000 ADD: out = a + b.
- 001 SUB: out = a − b (two's complement wrap).
- 010 INC: out = a + 1.
- 011 DEC: out = a − 1.
- 100 CMP: out = {1'b0, a>b, a<b, a==b}. Exactly one of bits [2:0] is set.
- 101 CNT_UP:
  - If the opcode executed on the previous edge was also 101, out = out + 1 (wraps 15→0).
  - Otherwise out = 0.
- 110 CNT_DN:
  - If the opcode executed on the previous edge was also 110, out = out − 1 (wraps 0→15).
  - Otherwise out = 0.
- 111 DBL: out = {a[2:0], 1'b0}, i.e. a×2 truncated to 4 bits. b is ignored.
- Operand use: b is used only by ADD, SUB and CMP; a is ignored by the counters.
- Continuation tracking: the block holds a "last executed opcode" register plus a valid flag, updated on every stage-2 edge.
  - A counter continues only when the flag is valid and the stored opcode matches the current one.
  - Any other opcode, or a switch between 101 and 110, restarts the count at 0.
- An instruction held constant on in for N cycles therefore produces 0, 1, 2, … (up) or 0, 15, 14, … (down) on consecutive edges.

## Timing
- Reset (asynchronous, any time, including mid-count):
  - out = 0; stage-1 opcode/a/b = 0; last-opcode valid flag = 0.
  - Takes effect immediately, not at the next edge.
- After reset deasserts, the stage-1 contents (ADD 0+0) yield out = 0 until real instructions arrive.
- Latency: an instruction/operand set stable before rising edge N is captured at edge N. Its result appears on out after edge N+1 and is held until edge N+2.
- Throughput: one instruction per clock; back-to-back instructions are fully pipelined with no stalls and no handshake.
- Counters advance once per clock while the counter opcode is the one in stage 1.
- When a new instruction enters stage 1, the counter gets one more update from the old opcode at the same edge (pipeline drain).

## Test plan
- Reset and arithmetic:
  - Assert rst → out = 0 asynchronously.
  - Release, then drive ADD a=6, b=3 → out = 9 two edges later.
  - Next cycle ADD 10+7 → out = 1 (wrap).
- Subtract and step:
  - SUB 7−2 → 5; SUB 2−4 → 14 (4'b1110).
  - INC 3 → 4; INC 15 → 0.
  - DEC 9 → 8; DEC 0 → 15.
- Compare:
  - CMP 5,2 → 4'b0100.
  - CMP 3,8 → 4'b0010.
  - CMP 4,4 → 4'b0001.
- Count up after CMP:
  - Hold opcode 101 → out = 0, 1, 2, … 15, then 0 on successive edges.
- Switch to count down:
  - Switch to 110 → out = 0 on the first down edge, then 15, 14, … 1, 0.
- Doubling and mid-count reset:
  - DBL a=3 → 6; DBL a=5 → 10 (b = 4, ignored).
  - Assert rst mid-count → out = 0 at once; after release, counting restarts from 0.

Source files
------------

// File: rtl/cbu.sv
// cbu: 4-bit computation block with a two-stage registered pipeline.
//
// Stage 1 captures the opcode (in[8:6]) and operands a/b on every rising
// edge. Stage 2 computes the registered result from the stage-1 contents.
// The up/down counter opcodes continue from the previous result only when
// the same counter opcode was executed on the previous stage-2 edge.
//
// Ports:
//   out  output [3:0]  registered result
//   in   input  [8:0]  instruction word; [8:6] opcode, [5:0] ignored
//   a    input  [3:0]  operand A (unsigned)
//   b    input  [3:0]  operand B (unsigned)
//   rst  input         asynchronous active-high reset
//   clk  input         rising-edge clock
module cbu (
    output logic [3:0] out,
    input  logic [8:0] in,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       rst,
    input  logic       clk
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_CMP = 3'b100;
    localparam logic [2:0] OP_CUP = 3'b101;
    localparam logic [2:0] OP_CDN = 3'b110;
    localparam logic [2:0] OP_DBL = 3'b111;

    logic [2:0] op_q, op_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] out_q, out_d;
    logic [2:0] last_op_q, last_op_d;
    logic       last_vld_q, last_vld_d;
    logic       cnt_cont;

    // Reserved instruction bits are intentionally ignored.
    logic unused_in;
    assign unused_in = ^in[5:0];

    always_comb begin
        op_d = in[8:6];
        a_d  = a;
        b_d  = b;

        // A counter continues only if the same counter opcode ran last edge;
        // switching between up and down also restarts from zero.
        cnt_cont = last_vld_q && (last_op_q == op_q);

        out_d = 4'd0;
        unique case (op_q)
            OP_ADD: out_d = a_q + b_q;
            OP_SUB: out_d = a_q - b_q;
            OP_INC: out_d = a_q + 4'd1;
            OP_DEC: out_d = a_q - 4'd1;
            OP_CMP: out_d = {1'b0, (a_q > b_q), (a_q < b_q), (a_q == b_q)};
            OP_CUP: out_d = cnt_cont ? (out_q + 4'd1) : 4'd0;
            OP_CDN: out_d = cnt_cont ? (out_q - 4'd1) : 4'd0;
            OP_DBL: out_d = {a_q[2:0], 1'b0};
            default: out_d = 4'd0;
        endcase

        last_op_d  = op_q;
        last_vld_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= 3'd0;
            a_q        <= 4'd0;
            b_q        <= 4'd0;
            out_q      <= 4'd0;
            last_op_q  <= 3'd0;
            last_vld_q <= 1'b0;
        end else begin
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            out_q      <= out_d;
            last_op_q  <= last_op_d;
            last_vld_q <= last_vld_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_cbu.sv
// Testbench for cbu: directed test-plan sequence followed by randomized
// instruction streams, all checked against an arithmetic reference model.
module tb_cbu;

    logic [3:0] out;
    logic [8:0] in;
    logic [3:0] a;
    logic [3:0] b;
    logic       rst;
    logic       clk;

    int checks;
    int errors;

    // Reference model: the instruction waiting to execute, the opcode that
    // executed last (or -1 when none since reset) and the current result.
    int m_pend_op, m_pend_a, m_pend_b;
    int m_prev_op;
    int m_out;

    cbu dut (
        .out(out),
        .in (in),
        .a  (a),
        .b  (b),
        .rst(rst),
        .clk(clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_calc(input int op, input int av, input int bv,
                                      input int prev_op, input int cur);
        int r;
        case (op)
            0: r = (av + bv) % 16;
            1: r = (av - bv + 16) % 16;
            2: r = (av + 1) % 16;
            3: r = (av + 15) % 16;
            4: r = (av > bv) ? 4 : ((av < bv) ? 2 : 1);
            5: r = (prev_op == 5) ? (cur + 1) % 16 : 0;
            6: r = (prev_op == 6) ? (cur + 15) % 16 : 0;
            default: r = (av * 2) % 16;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_pend_op = 0;
        m_pend_a  = 0;
        m_pend_b  = 0;
        m_prev_op = -1;
        m_out     = 0;
    endtask

    task automatic check(input string tag, input logic [3:0] exp);
        checks++;
        assert (out === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, out, exp);
        end
    endtask

    // Drive one instruction (called around the falling edge), let one rising
    // edge pass, update the model, and compare on the following falling edge.
    task automatic step(input string tag, input int op, input int av, input int bv);
        int nxt;
        in = {3'(op), 6'($urandom_range(0, 63))};
        a  = 4'(av);
        b  = 4'(bv);
        @(posedge clk);
        nxt       = model_calc(m_pend_op, m_pend_a, m_pend_b, m_prev_op, m_out);
        m_prev_op = m_pend_op;
        m_out     = nxt;
        m_pend_op = op;
        m_pend_a  = av;
        m_pend_b  = bv;
        @(negedge clk);
        check(tag, 4'(m_out));
    endtask

    // Asynchronous reset pulse starting between edges; out must clear at once.
    task automatic pulse_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check(tag, 4'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int op, n;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        in  = 9'd0;
        a   = 4'd0;
        b   = 4'd0;
        model_reset();
        #1;
        check("reset_async", 4'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset and arithmetic
        step("add_6_3_issue", 0, 6, 3);
        check("post_reset_idle", 4'd0);
        step("add_10_7_issue", 0, 10, 7);
        check("add_6_3", 4'd9);
        step("sub_7_2_issue", 1, 7, 2);
        check("add_wrap", 4'd1);
        step("sub_2_4_issue", 1, 2, 4);
        check("sub_7_2", 4'd5);
        step("inc_3_issue", 2, 3, 9);
        check("sub_wrap", 4'd14);
        step("inc_15_issue", 2, 15, 0);
        check("inc_3", 4'd4);
        step("dec_9_issue", 3, 9, 1);
        check("inc_wrap", 4'd0);
        step("dec_0_issue", 3, 0, 7);
        check("dec_9", 4'd8);
        step("cmp_5_2_issue", 4, 5, 2);
        check("dec_wrap", 4'd15);
        step("cmp_3_8_issue", 4, 3, 8);
        check("cmp_gt", 4'b0100);
        step("cmp_4_4_issue", 4, 4, 4);
        check("cmp_lt", 4'b0010);

        // Count up: 0,1,...,15,0
        step("cup_0", 5, 11, 3);
        check("cmp_eq", 4'b0001);
        for (int i = 0; i < 17; i++) begin
            step("cup_run", 5, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            check("cup_seq", 4'(i % 16));
        end

        // Switch to count down: 0 (drain of up gives 1 first), then 0,15,...
        step("cdn_switch", 6, 0, 0);
        check("cup_drain", 4'd1);
        for (int i = 0; i < 17; i++) begin
            step("cdn_run", 6, int'($urandom_range(0, 15)), 0);
            check("cdn_seq", 4'((16 - i) % 16));
        end

        // Doubling
        step("dbl_3_issue", 7, 3, 4);
        step("dbl_5_issue", 7, 5, 4);
        check("dbl_3", 4'd6);
        step("cup_again", 5, 0, 0);
        check("dbl_5", 4'd10);
        for (int i = 0; i < 4; i++) step("cup_pre_rst", 5, 0, 0);
        check("cup_pre_rst_val", 4'd3);

        // Mid-count reset, then counting restarts from zero
        pulse_reset("reset_mid_count");
        step("cup_after_rst_a", 5, 0, 0);
        check("cup_after_rst_idle", 4'd0);
        step("cup_after_rst_b", 5, 0, 0);
        check("cup_restart_0", 4'd0);
        step("cup_after_rst_c", 5, 0, 0);
        check("cup_restart_1", 4'd1);

        // Randomized instruction streams with runs of repeated opcodes
        for (int k = 0; k < 200; k++) begin
            op = int'($urandom_range(0, 7));
            n  = int'($urandom_range(1, 5));
            for (int j = 0; j < n; j++)
                step("rand", op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            if ($urandom_range(0, 39) == 0) pulse_reset("rand_reset");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
